audio_fifo_ctrl: RTL and testbench
==================================

Name: audio_fifo_ctrl

Overview:
APB-writable stereo sample buffer that feeds the audio datapath. Software pushes 24-bit left and right samples through two APB write addresses. Each sample request (tick_in) from the downstream rate generator pops one sample per channel onto audio0_out/audio1_out and pulses tick_out. When a FIFO is empty the block outputs zeros, so an undriven stream drains to silence within AUDIO_FIFO_SIZE ticks.

Parameters:
DEPTH, AUDIO_FIFO_SIZE (16), entries per channel FIFO, power of two, >= 4
LEVEL_W, $clog2(DEPTH)+1, width of each level counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  APB write
PADDR  in  32  APB address
PWDATA  in  32  APB write data, sample in [23:0]
PRDATA  out  32  APB read data
PREADY  out  1  APB ready, tied 1
PSLVERR  out  1  APB error
tick_in  in  1  one-cycle sample request
play_in  in  1  playback enable
clr_in  in  1  synchronous flush of both FIFOs
audio0_out  out  24  left sample
audio1_out  out  24  right sample
tick_out  out  1  one-cycle valid strobe for audio0/1_out
req_out  out  1  one-cycle refill request
underrun_out  out  1  sticky underrun flag

Behaviour:
- Reset values: all outputs 0 except PREADY=1. FIFOs empty, pointers 0, underrun 0.
- Access phase is PSEL&&PENABLE. Address match is an exact 32-bit compare. Zero wait states.
- Write to LEFT_FIFO_ADDRESS pushes PWDATA[23:0] into the left FIFO. RIGHT_FIFO_ADDRESS pushes into the right FIFO. Upper PWDATA bits are ignored.
- Push to a full FIFO: data is dropped, contents are unchanged, and PSLVERR=1 in that access phase (combinational). Otherwise PSLVERR=0.
- Push to a full FIFO in the same cycle as a pop of that FIFO: the push is accepted, PSLVERR=0, and the level is unchanged.
- Read of FIFO_STATUS_ADDRESS returns PRDATA[7:0]=left level, [15:8]=right level, [16]=underrun, all other bits 0. The read clears underrun at the end of the access phase, unless an underrun occurs in the same cycle (set wins).
- Reads of any other address return 0. Writes to any other address are ignored.
- Pop event = tick_in && play_in && !clr_in.
  - One cycle after a pop event: tick_out=1 for exactly one cycle and audio0/1_out are registered.
  - Each channel outputs its head sample if non-empty, else 24'h0.
  - If either FIFO was empty, underrun is set. A non-empty channel still pops.
- Push and pop in the same cycle on an empty FIFO: the pop sees empty (output 0, underrun set) and the push is stored. There is no bypass path.
- play_in=0: ticks are ignored, no tick_out, outputs hold their last value.
- Falling edge of play_in: audio0/1_out are cleared to 0 on the next cycle.
- clr_in=1: both FIFOs are emptied, audio0/1_out=0, and there is no tick_out. clr_in has priority over a push or pop in the same cycle. Underrun is not affected.
- req_out=1 for one cycle when a pop moves the left level from DEPTH/2+1 to DEPTH/2.
- Pointers are DEPTH-modulo and wrap naturally. The level counter saturates logically at DEPTH (full).
- Latency: APB write to sample visible at output is at least 2 cycles (push, then next pop event).
- Reset asserted mid-operation: everything returns immediately to reset values (asynchronous).

Decomposition:
- audioport_pkg holds:
  - LEFT_FIFO_ADDRESS, RIGHT_FIFO_ADDRESS, FIFO_STATUS_ADDRESS
  - AUDIO_FIFO_SIZE
  - typedef audio_sample_t (logic [23:0])
- One sub-module, sample_fifo, instantiated twice (left/right):
  - Parameter DEPTH.
  - Ports: clk, rst_n, clr, push, pop, din, dout (head, combinational), full, empty, level.

Test Plan:
- Reset, then write L=24'h000001..000004 and R=24'h100001..100004, then 4 ticks with play_in=1 -> outputs (000001,100001)..(000004,100004), each one cycle after its tick with tick_out=1.
- Empty FIFOs, 1 tick -> outputs 0/0, tick_out=1, underrun_out=1. Status read returns PRDATA=32'h0001_0000. The next status read returns 0.
- Push 17 left samples with DEPTH=16 -> 17th write has PSLVERR=1 and left level reads 16. A write in the same cycle as a pop is accepted with PSLVERR=0.
- Fill the left FIFO to 9 entries, pop once -> req_out pulses once at level 8. Further pops produce no req_out.
- Fill both FIFOs to 5 entries, assert clr_in together with tick_in and an APB write -> levels 0, outputs 0, no tick_out.
- Load 3 samples, deassert play_in -> outputs become 0. Ticks are ignored and levels stay at 3. Assert rst_n=0 mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/audioport_pkg.sv
// Shared constants and types for the APB-fed stereo sample buffer.
package audioport_pkg;

    localparam int unsigned AUDIO_FIFO_SIZE = 16;
    localparam int unsigned SAMPLE_W        = 24;

    localparam logic [31:0] LEFT_FIFO_ADDRESS   = 32'h8C00_0000;
    localparam logic [31:0] RIGHT_FIFO_ADDRESS  = 32'h8C00_0004;
    localparam logic [31:0] FIFO_STATUS_ADDRESS = 32'h8C00_0008;

    typedef logic [SAMPLE_W-1:0] audio_sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-channel sample FIFO with combinational head output and level counter.
module sample_fifo
    import audioport_pkg::*;
#(
    parameter  int unsigned DEPTH   = AUDIO_FIFO_SIZE,
    localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               push,
    input  logic               pop,
    input  audio_sample_t      din,
    output audio_sample_t      dout,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    audio_sample_t    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LEVEL_W'(DEPTH));
    assign dout    = mem[rd_ptr];
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/audio_fifo_ctrl.sv
// APB-writable stereo sample buffer; each sample request pops one sample per channel.
module audio_fifo_ctrl
    import audioport_pkg::*;
#(
    parameter int unsigned DEPTH = AUDIO_FIFO_SIZE
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic          PWRITE,
    input  logic [31:0]   PADDR,
    input  logic [31:0]   PWDATA,
    output logic [31:0]   PRDATA,
    output logic          PREADY,
    output logic          PSLVERR,
    input  logic          tick_in,
    input  logic          play_in,
    input  logic          clr_in,
    output audio_sample_t audio0_out,
    output audio_sample_t audio1_out,
    output logic          tick_out,
    output logic          req_out,
    output logic          underrun_out
);

    localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1;

    logic               access;
    logic               wr_left;
    logic               wr_right;
    logic               rd_status;
    logic               pop_ev;
    logic               play_d;
    logic               left_full;
    logic               left_empty;
    logic               right_full;
    logic               right_empty;
    logic [LEVEL_W-1:0] left_level;
    logic [LEVEL_W-1:0] right_level;
    audio_sample_t      left_head;
    audio_sample_t      right_head;
    logic               left_pop_eff;
    logic               left_push_eff;
    logic               underrun_set;
    logic               unused_pwdata;

    assign unused_pwdata = ^PWDATA[31:SAMPLE_W];

    assign access    = PSEL && PENABLE;
    assign wr_left   = access && PWRITE && (PADDR == LEFT_FIFO_ADDRESS);
    assign wr_right  = access && PWRITE && (PADDR == RIGHT_FIFO_ADDRESS);
    assign rd_status = access && !PWRITE && (PADDR == FIFO_STATUS_ADDRESS);
    assign pop_ev    = tick_in && play_in && !clr_in;

    assign left_pop_eff  = pop_ev && !left_empty;
    assign left_push_eff = wr_left && (!left_full || left_pop_eff);
    assign underrun_set  = pop_ev && (left_empty || right_empty);

    assign PREADY  = 1'b1;
    assign PSLVERR = (wr_left && left_full && !pop_ev) || (wr_right && right_full && !pop_ev);
    assign PRDATA  = rd_status ? {15'd0, underrun_out, 8'(right_level), 8'(left_level)} : 32'd0;

    sample_fifo #(.DEPTH(DEPTH)) u_left (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_in),
        .push  (wr_left),
        .pop   (pop_ev),
        .din   (audio_sample_t'(PWDATA[SAMPLE_W-1:0])),
        .dout  (left_head),
        .full  (left_full),
        .empty (left_empty),
        .level (left_level)
    );

    sample_fifo #(.DEPTH(DEPTH)) u_right (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_in),
        .push  (wr_right),
        .pop   (pop_ev),
        .din   (audio_sample_t'(PWDATA[SAMPLE_W-1:0])),
        .dout  (right_head),
        .full  (right_full),
        .empty (right_empty),
        .level (right_level)
    );

    // Output sample registers: flush and play-stop force silence, empty channels emit zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio0_out <= '0;
            audio1_out <= '0;
            tick_out   <= 1'b0;
            play_d     <= 1'b0;
        end else begin
            play_d   <= play_in;
            tick_out <= 1'b0;
            if (clr_in) begin
                audio0_out <= '0;
                audio1_out <= '0;
            end else if (pop_ev) begin
                audio0_out <= left_empty  ? '0 : left_head;
                audio1_out <= right_empty ? '0 : right_head;
                tick_out   <= 1'b1;
            end else if (play_d && !play_in) begin
                audio0_out <= '0;
                audio1_out <= '0;
            end
        end
    end

    // Refill request fires only when a pop actually lowers the left level to half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_out <= 1'b0;
        end else begin
            req_out <= left_pop_eff && !left_push_eff
                       && (left_level == LEVEL_W'(DEPTH / 2 + 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_out <= 1'b0;
        end else if (underrun_set) begin
            underrun_out <= 1'b1;
        end else if (rd_status) begin
            underrun_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_fifo_ctrl.sv
// Directed bench for audio_fifo_ctrl with a queue-based reference model checked every cycle.
module tb_audio_fifo_ctrl;
    import audioport_pkg::*;

    localparam int unsigned D = AUDIO_FIFO_SIZE;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          PSEL, PENABLE, PWRITE;
    logic [31:0]   PADDR, PWDATA, PRDATA;
    logic          PREADY, PSLVERR;
    logic          tick_in, play_in, clr_in;
    audio_sample_t audio0_out, audio1_out;
    logic          tick_out, req_out, underrun_out;

    audio_fifo_ctrl #(.DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tick_in(tick_in), .play_in(play_in), .clr_in(clr_in),
        .audio0_out(audio0_out), .audio1_out(audio1_out),
        .tick_out(tick_out), .req_out(req_out), .underrun_out(underrun_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    audio_sample_t ql[$];
    audio_sample_t qr[$];
    audio_sample_t m_a0, m_a1;
    logic          m_tick, m_req, m_und, m_play_d;
    logic [31:0]   seen_prdata;
    logic          seen_slverr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ql.delete(); qr.delete();
        m_a0 = '0; m_a1 = '0; m_tick = 0; m_req = 0; m_und = 0; m_play_d = 0;
    endtask

    function automatic logic [31:0] exp_prdata();
        if (PSEL && PENABLE && !PWRITE && PADDR == FIFO_STATUS_ADDRESS)
            return {15'd0, m_und, 8'(qr.size()), 8'(ql.size())};
        return 32'd0;
    endfunction

    function automatic logic exp_slverr();
        logic w   = PSEL && PENABLE && PWRITE;
        logic pop = tick_in && play_in && !clr_in;
        return (w && PADDR == LEFT_FIFO_ADDRESS  && ql.size() == D && !pop) ||
               (w && PADDR == RIGHT_FIFO_ADDRESS && qr.size() == D && !pop);
    endfunction

    // Advance the reference model by one clock using the current inputs.
    task automatic model_step();
        logic pop   = tick_in && play_in && !clr_in;
        logic wl    = PSEL && PENABLE && PWRITE && PADDR == LEFT_FIFO_ADDRESS;
        logic wr    = PSEL && PENABLE && PWRITE && PADDR == RIGHT_FIFO_ADDRESS;
        logic rd    = PSEL && PENABLE && !PWRITE && PADDR == FIFO_STATUS_ADDRESS;
        logic el    = (ql.size() == 0);
        logic er    = (qr.size() == 0);
        logic acc_l = wl && (ql.size() < D || (pop && !el));
        logic acc_r = wr && (qr.size() < D || (pop && !er));
        if (pop && (el || er)) m_und = 1;
        else if (rd)           m_und = 0;
        m_req  = 0;
        m_tick = 0;
        if (clr_in) begin
            ql.delete(); qr.delete();
            m_a0 = '0; m_a1 = '0;
        end else begin
            if (pop) begin
                m_req  = !el && !acc_l && (ql.size() == D / 2 + 1);
                m_tick = 1;
                if (el) m_a0 = '0; else m_a0 = ql.pop_front();
                if (er) m_a1 = '0; else m_a1 = qr.pop_front();
            end else if (m_play_d && !play_in) begin
                m_a0 = '0; m_a1 = '0;
            end
            if (acc_l) ql.push_back(PWDATA[23:0]);
            if (acc_r) qr.push_back(PWDATA[23:0]);
        end
        m_play_d = play_in;
    endtask

    // One clock: combinational APB checks, edge, then registered output checks.
    task automatic cyc();
        #1;
        seen_prdata = PRDATA;
        seen_slverr = PSLVERR;
        chk("prdata", PRDATA, exp_prdata());
        chk("pslverr", 32'(PSLVERR), 32'(exp_slverr()));
        chk("pready", 32'(PREADY), 32'd1);
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("audio0", 32'(audio0_out), 32'(m_a0));
        chk("audio1", 32'(audio1_out), 32'(m_a1));
        chk("tick_out", 32'(tick_out), 32'(m_tick));
        chk("req_out", 32'(req_out), 32'(m_req));
        chk("underrun", 32'(underrun_out), 32'(m_und));
    endtask

    task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic tk);
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = a; PWDATA = d;
        cyc();
        PENABLE = 1; tick_in = tk;
        cyc();
        PSEL = 0; PENABLE = 0; PWRITE = 0; tick_in = 0;
    endtask

    task automatic tick();
        tick_in = 1;
        cyc();
        tick_in = 0;
    endtask

    initial begin
        rst_n = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        tick_in = 0; play_in = 0; clr_in = 0;
        model_reset();
        @(negedge clk);
        chk("rst_audio0", 32'(audio0_out), 32'd0);
        chk("rst_tick", 32'(tick_out), 32'd0);
        chk("rst_under", 32'(underrun_out), 32'd0);
        chk("rst_pready", 32'(PREADY), 32'd1);
        chk("rst_prdata", PRDATA, 32'd0);
        rst_n = 1;
        cyc();

        // Basic stereo playback.
        for (int i = 1; i <= 4; i++) begin
            apb(1, LEFT_FIFO_ADDRESS,  32'hFF00_0000 | 32'(i), 0);
            apb(1, RIGHT_FIFO_ADDRESS, 32'h0010_0000 + 32'(i), 0);
        end
        play_in = 1;
        cyc();
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("play_l", 32'(audio0_out), 32'(i));
            chk("play_r", 32'(audio1_out), 32'h0010_0000 + 32'(i));
            chk("play_tick", 32'(tick_out), 32'd1);
            cyc();
        end

        // Underrun on empty, sticky until a status read.
        tick();
        chk("und_l", 32'(audio0_out), 32'd0);
        chk("und_tick", 32'(tick_out), 32'd1);
        chk("und_flag", 32'(underrun_out), 32'd1);
        apb(0, FIFO_STATUS_ADDRESS, 32'd0, 0);
        chk("status1", seen_prdata, 32'h0001_0000);
        apb(0, FIFO_STATUS_ADDRESS, 32'd0, 0);
        chk("status2", seen_prdata, 32'h0000_0000);

        // Overflow left FIFO, then push concurrent with a pop.
        for (int i = 0; i < 17; i++) apb(1, LEFT_FIFO_ADDRESS, 32'h0020_0000 + 32'(i), 0);
        chk("ovf_slverr", 32'(seen_slverr), 32'd1);
        apb(0, FIFO_STATUS_ADDRESS, 32'd0, 0);
        chk("ovf_level", seen_prdata, 32'h0000_0010);
        apb(1, LEFT_FIFO_ADDRESS, 32'h0020_0099, 1);
        chk("pushpop_slverr", 32'(seen_slverr), 32'd0);
        chk("pushpop_head", 32'(audio0_out), 32'h0020_0000);
        apb(0, FIFO_STATUS_ADDRESS, 32'd0, 0);
        chk("pushpop_level", seen_prdata, 32'h0001_0010);

        // Refill request at the half-full crossing.
        clr_in = 1; cyc(); clr_in = 0;
        for (int i = 0; i < 9; i++) apb(1, LEFT_FIFO_ADDRESS, 32'h0030_0000 + 32'(i), 0);
        tick();
        chk("req_first", 32'(req_out), 32'd1);
        cyc();
        tick();
        chk("req_second", 32'(req_out), 32'd0);
        tick();
        chk("req_third", 32'(req_out), 32'd0);

        // Flush wins over a simultaneous tick and push.
        for (int i = 0; i < 5; i++) begin
            apb(1, LEFT_FIFO_ADDRESS,  32'h0040_0000 + 32'(i), 0);
            apb(1, RIGHT_FIFO_ADDRESS, 32'h0050_0000 + 32'(i), 0);
        end
        tick();
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = LEFT_FIFO_ADDRESS; PWDATA = 32'h0040_00AA;
        cyc();
        PENABLE = 1; tick_in = 1; clr_in = 1;
        cyc();
        PSEL = 0; PENABLE = 0; PWRITE = 0; tick_in = 0; clr_in = 0;
        chk("clr_l", 32'(audio0_out), 32'd0);
        chk("clr_r", 32'(audio1_out), 32'd0);
        chk("clr_tick", 32'(tick_out), 32'd0);
        apb(0, FIFO_STATUS_ADDRESS, 32'd0, 0);
        chk("clr_levels", 32'(seen_prdata[15:0]), 32'h0000);

        // Stop playback: silence, ticks ignored, levels held.
        for (int i = 1; i <= 4; i++) begin
            apb(1, LEFT_FIFO_ADDRESS,  32'h0030_0000 + 32'(i), 0);
            apb(1, RIGHT_FIFO_ADDRESS, 32'h0040_0000 + 32'(i), 0);
        end
        tick();
        chk("stop_pre", 32'(audio0_out), 32'h0030_0001);
        play_in = 0;
        cyc();
        chk("stop_l", 32'(audio0_out), 32'd0);
        chk("stop_r", 32'(audio1_out), 32'd0);
        tick();
        chk("stop_tick", 32'(tick_out), 32'd0);
        apb(0, FIFO_STATUS_ADDRESS, 32'd0, 0);
        chk("stop_levels", 32'(seen_prdata[15:0]), 32'h0303);

        // Asynchronous reset mid-stream.
        play_in = 1;
        cyc();
        tick();
        chk("resume_l", 32'(audio0_out), 32'h0030_0002);
        #2 rst_n = 0;
        #1;
        chk("arst_l", 32'(audio0_out), 32'd0);
        chk("arst_r", 32'(audio1_out), 32'd0);
        chk("arst_tick", 32'(tick_out), 32'd0);
        chk("arst_req", 32'(req_out), 32'd0);
        chk("arst_under", 32'(underrun_out), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        cyc();
        tick();
        chk("post_rst_l", 32'(audio0_out), 32'd0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
